spi_fifo_register_map: RTL and testbench

Next-generation SPI register map with parametrised data width, FIFO depth and slave-select count.
- Adds TX/RX FIFOs, so software can queue bursts instead of writing one SPDR byte per transfer.
- Sits between the ram_if CPU bus and the SPI shift core. Launches queued transfers and collects received words.
- Config changes are applied only between transfers. Raises a maskable combined interrupt.

---
 rtl/spi_fifo_pkg.sv | 58 +++++
 rtl/spi_fifo_register_map_fifo.sv | 56 +++++
 rtl/spi_fifo_register_map.sv | 195 +++++++++++++++++++
 tb/tb_spi_fifo_register_map.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the FIFO-based SPI register map: bus addresses, reset
// values, register layouts and the transfer sequencer states.
package spi_fifo_pkg;

  localparam logic [7:0] SPCR_ADDR     = 8'h00;
  localparam logic [7:0] SPSR_ADDR     = 8'h01;
  localparam logic [7:0] SPDR_ADDR     = 8'h02;
  localparam logic [7:0] PORTB_ADDR    = 8'h03;
  localparam logic [7:0] FIFOCTL_ADDR  = 8'h04;
  localparam logic [7:0] FIFOSTAT_ADDR = 8'h05;

  localparam logic [7:0] SPCR_INIT  = 8'h00;
  localparam logic       SPI2X_INIT = 1'b0;
  // Slave selects are active low, so every select line idles high.
  localparam logic       PB_INIT    = 1'b1;

  typedef struct packed {
    logic       spie;
    logic       spe;
    logic       dord;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic [1:0] spr;
  } spcr_t;

  typedef struct packed {
    logic       spif;
    logic       wcol;
    logic       rovr;
    logic       txe;
    logic       rxne;
    logic [1:0] rsvd;
    logic       spi2x;
  } spsr_t;

  typedef struct packed {
    logic       txflush;
    logic       rxflush;
    logic [3:0] rsvd;
    logic       rxie;
    logic       txeie;
  } fifoctl_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_LAUNCH,
    S_BUSY
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(4);

endpackage

// File: rtl/spi_fifo_register_map_fifo.sv
// Synchronous first-word-fall-through FIFO; flush overrides any same-cycle push.
module spi_sync_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_fifo_register_map.sv
// CPU-facing SPI register map with TX/RX FIFOs; config changes are staged and
// applied only while the shift core is idle.
module spi_fifo_register_map
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_SS     = 5
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  ram_enable,
  input  logic                  ram_wren,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] ram_q,
  input  logic [DATA_WIDTH-1:0] rxb,
  input  logic                  txc,
  input  logic                  transfor,
  input  logic                  irq_ack,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] txb,
  output logic                  spe,
  output logic                  spie,
  output logic                  dord,
  output logic                  cpol,
  output logic                  cpha,
  output logic [2:0]            clock_rate,
  output logic [NUM_SS-1:0]     pb,
  output logic                  irq
);

  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] A_SPCR     = ADDR_WIDTH'(SPCR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_SPSR     = ADDR_WIDTH'(SPSR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_SPDR     = ADDR_WIDTH'(SPDR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_PORTB    = ADDR_WIDTH'(PORTB_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_FIFOCTL  = ADDR_WIDTH'(FIFOCTL_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_FIFOSTAT = ADDR_WIDTH'(FIFOSTAT_ADDR);
  localparam spcr_t SPCR_RST = spcr_t'(SPCR_INIT);

  state_e                state_q;
  spcr_t                 spcr_q;
  logic                  spi2x_q, spif_q, wcol_q, rovr_q, rxie_q, txeie_q, pending_q;
  logic [NUM_SS-1:0]     pb_q;
  logic                  tx_start_q, spe_q, spie_q, dord_q, cpol_q, cpha_q;
  logic [2:0]            clock_rate_q;
  logic [DATA_WIDTH-1:0] txb_q, rdata_q, rdata_d;

  logic                  wr, rd, wr_spcr, wr_spsr, wr_spdr, wr_portb, wr_fifoctl;
  logic                  rd_spsr, rd_spdr, tx_flush, rx_flush, launch;
  logic                  tx_pop, rx_push, rx_pop, wcol_set, rovr_set;
  logic [DATA_WIDTH-1:0] tx_head, rx_head;
  logic [CW-1:0]         tx_count, rx_count;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  spsr_t                 spsr_rd;
  fifoctl_t              fifoctl_rd;

  assign wr         = ram_enable & ram_wren;
  assign rd         = ram_enable & ~ram_wren;
  assign wr_spcr    = wr && (ram_addr == A_SPCR);
  assign wr_spsr    = wr && (ram_addr == A_SPSR);
  assign wr_spdr    = wr && (ram_addr == A_SPDR);
  assign wr_portb   = wr && (ram_addr == A_PORTB);
  assign wr_fifoctl = wr && (ram_addr == A_FIFOCTL);
  assign rd_spsr    = rd && (ram_addr == A_SPSR);
  assign rd_spdr    = rd && (ram_addr == A_SPDR);
  assign tx_flush   = wr_fifoctl & ram_data[7];
  assign rx_flush   = wr_fifoctl & ram_data[6];

  // A staged config update always goes out before the next word is launched.
  assign launch   = (state_q == S_IDLE) & ~pending_q & spe_q & ~tx_empty & ~transfor;
  assign tx_pop   = launch;
  assign rx_push  = txc & (state_q == S_BUSY);
  assign rx_pop   = rd_spdr & ~rx_empty;
  assign wcol_set = wr_spdr & tx_full & ~tx_pop & ~tx_flush;
  assign rovr_set = rx_push & rx_full & ~rx_pop & ~rx_flush;

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_(rst_), .push(wr_spdr), .wdata(ram_data), .pop(tx_pop),
    .flush(tx_flush), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_(rst_), .push(rx_push), .wdata(rxb), .pop(rx_pop),
    .flush(rx_flush), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      spcr_q  <= SPCR_RST;
      spi2x_q <= SPI2X_INIT;
      pb_q    <= {NUM_SS{PB_INIT}};
      rxie_q  <= 1'b0;
      txeie_q <= 1'b0;
      spif_q  <= 1'b0;
      wcol_q  <= 1'b0;
      rovr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (wr_spcr)    spcr_q  <= spcr_t'(ram_data[7:0]);
      if (wr_spsr)    spi2x_q <= ram_data[0];
      if (wr_portb)   pb_q    <= ram_data[NUM_SS-1:0];
      if (wr_fifoctl) begin
        rxie_q  <= ram_data[1];
        txeie_q <= ram_data[0];
      end
      spif_q  <= txc | (spif_q & ~(irq_ack | rd_spsr));
      wcol_q  <= wcol_set | (wcol_q & ~rd_spsr);
      rovr_q  <= rovr_set | (rovr_q & ~rd_spsr);
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    spsr_rd       = '0;
    spsr_rd.spif  = spif_q;
    spsr_rd.wcol  = wcol_q;
    spsr_rd.rovr  = rovr_q;
    spsr_rd.txe   = tx_empty;
    spsr_rd.rxne  = ~rx_empty;
    spsr_rd.spi2x = spi2x_q;
    fifoctl_rd       = '0;
    fifoctl_rd.rxie  = rxie_q;
    fifoctl_rd.txeie = txeie_q;
    rdata_d = rdata_q;
    if (rd) begin
      case (ram_addr)
        A_SPCR:     rdata_d = DATA_WIDTH'(spcr_q);
        A_SPSR:     rdata_d = DATA_WIDTH'(spsr_rd);
        A_SPDR:     rdata_d = rx_empty ? '0 : rx_head;
        A_PORTB:    rdata_d = DATA_WIDTH'(pb_q);
        A_FIFOCTL:  rdata_d = DATA_WIDTH'(fifoctl_rd);
        A_FIFOSTAT: rdata_d = DATA_WIDTH'({4'(rx_count), 4'(tx_count)});
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      txb_q        <= '0;
      spe_q        <= SPCR_RST.spe;
      spie_q       <= SPCR_RST.spie;
      dord_q       <= SPCR_RST.dord;
      cpol_q       <= SPCR_RST.cpol;
      cpha_q       <= SPCR_RST.cpha;
      clock_rate_q <= {SPI2X_INIT, SPCR_RST.spr};
    end else begin
      tx_start_q <= 1'b0;
      if (wr_spcr || wr_spsr)     pending_q <= 1'b1;
      else if (state_q == S_UPDATE) pending_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q && !transfor) begin
            state_q <= S_UPDATE;
          end else if (launch) begin
            state_q    <= S_LAUNCH;
            txb_q      <= tx_head;
            tx_start_q <= 1'b1;
          end
        end
        S_UPDATE: begin
          spe_q        <= spcr_q.spe;
          spie_q       <= spcr_q.spie;
          dord_q       <= spcr_q.dord;
          cpol_q       <= spcr_q.cpol;
          cpha_q       <= spcr_q.cpha;
          clock_rate_q <= {spi2x_q, spcr_q.spr};
          state_q      <= S_IDLE;
        end
        S_LAUNCH: state_q <= S_BUSY;
        S_BUSY:   if (txc) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_q      = rdata_q;
  assign tx_start   = tx_start_q;
  assign txb        = txb_q;
  assign spe        = spe_q;
  assign spie       = spie_q;
  assign dord       = dord_q;
  assign cpol       = cpol_q;
  assign cpha       = cpha_q;
  assign clock_rate = clock_rate_q;
  assign pb         = pb_q;
  assign irq        = spie_q & (spif_q | (txeie_q & tx_empty) | (rxie_q & ~rx_empty));

endmodule

// File: tb/tb_spi_fifo_register_map.sv
// Directed bench for spi_fifo_register_map with a simple echoing shift-core model.
module tb_spi_fifo_register_map;
  import spi_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_;
  logic       ram_enable, ram_wren;
  logic [7:0] ram_addr, ram_data, ram_q;
  logic [7:0] rxb;
  logic       txc, transfor, irq_ack;
  logic       tx_start;
  logic [7:0] txb;
  logic       spe, spie, dord, cpol, cpha, irq;
  logic [2:0] clock_rate;
  logic [4:0] pb;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] launches[$];
  int         gaps[$];
  int         last_txc_cyc;
  bit         have_txc;
  bit         core_en;
  int         core_lat;
  logic [7:0] rv;

  spi_fifo_register_map #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .FIFO_DEPTH(4), .NUM_SS(5)
  ) dut (
    .clk(clk), .rst_(rst_), .ram_enable(ram_enable), .ram_wren(ram_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .rxb(rxb), .txc(txc), .transfor(transfor), .irq_ack(irq_ack),
    .tx_start(tx_start), .txb(txb), .spe(spe), .spie(spie), .dord(dord),
    .cpol(cpol), .cpha(cpha), .clock_rate(clock_rate), .pb(pb), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core echoes the inverted word back core_lat cycles after each launch.
  initial begin
    logic [7:0] txw;
    txc = 1'b0;
    rxb = '0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        txw = txb;
        launches.push_back(txw);
        if (have_txc) gaps.push_back(cyc - last_txc_cyc);
        if (core_en) begin
          for (int k = 0; k < core_lat; k++) @(negedge clk);
          if (core_en) begin
            rxb = ~txw;
            txc = 1'b1;
            last_txc_cyc = cyc;
            have_txc = 1'b1;
            @(negedge clk);
            txc = 1'b0;
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ram_enable = 1'b1; ram_wren = 1'b1; ram_addr = a; ram_data = d;
    @(negedge clk);
    ram_enable = 1'b0; ram_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    ram_enable = 1'b1; ram_wren = 1'b0; ram_addr = a;
    @(negedge clk);
    ram_enable = 1'b0;
    d = ram_q;
  endtask

  task automatic wait_launches(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (launches.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, launches.size(), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    ram_enable = 1'b0; ram_wren = 1'b0; ram_addr = '0; ram_data = '0;
    transfor = 1'b0; irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    launches.delete();
    gaps.delete();
    have_txc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    core_en = 1'b1; core_lat = 2; have_txc = 1'b0; last_txc_cyc = 0;
    rst_ = 1'b0; ram_enable = 1'b0; ram_wren = 1'b0; ram_addr = '0; ram_data = '0;
    transfor = 1'b0; irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_txb", txb, 8'h00);
    check_eq("rst_cfg", {spe, spie, dord, cpol, cpha, clock_rate}, 8'h00);
    check_eq("rst_pb", pb, 5'h1F);
    check_eq("rst_irq_q", {irq, ram_q}, 9'h000);
    rst_ = 1'b1;

    // Three-word burst with echoed receive data
    bus_write(SPCR_ADDR, 8'hC0);
    bus_write(SPDR_ADDR, 8'h11);
    bus_write(SPDR_ADDR, 8'h22);
    bus_write(SPDR_ADDR, 8'h33);
    wait_launches("burst_launches", 3, 200);
    repeat (6) @(negedge clk);
    check_eq("burst_txb0", launches[0], 8'h11);
    check_eq("burst_txb1", launches[1], 8'h22);
    check_eq("burst_txb2", launches[2], 8'h33);
    check_eq("burst_gap", gaps[0], 2);
    bus_read(SPDR_ADDR, rv);     check_eq("burst_rx0", rv, 8'hEE);
    bus_read(SPDR_ADDR, rv);     check_eq("burst_rx1", rv, 8'hDD);
    bus_read(SPDR_ADDR, rv);     check_eq("burst_rx2", rv, 8'hCC);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("burst_stat", rv, 8'h00);
    bus_read(SPSR_ADDR, rv);     check_eq("burst_spsr1", rv, 8'h90);
    bus_read(SPSR_ADDR, rv);     check_eq("burst_spsr2", rv, 8'h10);

    // TX overflow with the core disabled, then flush; PORTB and unmapped read
    do_reset();
    for (int i = 0; i < 5; i++) bus_write(SPDR_ADDR, 8'hA1 + 8'(i));
    bus_read(FIFOSTAT_ADDR, rv); check_eq("wcol_stat", rv, 8'h04);
    bus_read(SPSR_ADDR, rv);     check_eq("wcol_spsr1", rv, 8'h40);
    bus_read(SPSR_ADDR, rv);     check_eq("wcol_spsr2", rv, 8'h00);
    bus_write(FIFOCTL_ADDR, 8'h80);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("txflush_stat", rv, 8'h00);
    bus_read(FIFOCTL_ADDR, rv);  check_eq("fifoctl_rd", rv, 8'h00);
    bus_write(PORTB_ADDR, 8'h0A);
    check_eq("pb_out", pb, 5'h0A);
    bus_read(PORTB_ADDR, rv);    check_eq("pb_rd", rv, 8'h0A);
    bus_read(8'h07, rv);         check_eq("unmapped_rd", rv, 8'h00);

    // RX overflow: five receptions into a depth-4 FIFO
    do_reset();
    bus_write(SPCR_ADDR, 8'h40);
    for (int i = 0; i < 5; i++) bus_write(SPDR_ADDR, 8'h01 + 8'(i));
    wait_launches("rovr_launches", 5, 200);
    repeat (6) @(negedge clk);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("rovr_stat", rv, 8'h40);
    bus_read(SPSR_ADDR, rv);     check_eq("rovr_spsr", rv, 8'hB8);
    bus_read(SPDR_ADDR, rv);     check_eq("rovr_pop0", rv, 8'hFE);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("rovr_stat2", rv, 8'h30);
    bus_read(SPDR_ADDR, rv);     check_eq("rovr_pop1", rv, 8'hFD);
    bus_read(SPDR_ADDR, rv);     check_eq("rovr_pop2", rv, 8'hFC);
    bus_read(SPDR_ADDR, rv);     check_eq("rovr_pop3", rv, 8'hFB);
    bus_read(SPDR_ADDR, rv);     check_eq("rx_empty_rd", rv, 8'h00);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("rovr_stat3", rv, 8'h00);

    // Config held back while the core reports busy
    do_reset();
    bus_write(SPCR_ADDR, 8'h40);
    repeat (3) @(negedge clk);
    transfor = 1'b1;
    bus_write(SPCR_ADDR, 8'h48);
    bus_write(SPDR_ADDR, 8'h55);
    bus_read(SPCR_ADDR, rv);     check_eq("staged_spcr_rd", rv, 8'h48);
    repeat (3) @(negedge clk);
    check_eq("held_cpol", cpol, 1'b0);
    check_eq("held_no_launch", launches.size(), 0);
    transfor = 1'b0;
    @(negedge clk); check_eq("upd_cpol_n1", cpol, 1'b0);
    @(negedge clk); check_eq("upd_cpol_n2", {cpol, tx_start}, 2'b10);
    @(negedge clk); check_eq("upd_launch", {tx_start, txb}, 9'h155);
    repeat (8) @(negedge clk);
    bus_read(SPDR_ADDR, rv);     check_eq("upd_rx", rv, 8'hAA);

    // Interrupt sources and acknowledge
    do_reset();
    bus_write(SPCR_ADDR, 8'hC0);
    bus_write(FIFOCTL_ADDR, 8'h02);
    repeat (3) @(negedge clk);
    check_eq("irq_idle", irq, 1'b0);
    bus_write(SPDR_ADDR, 8'h3C);
    wait_launches("irq_launch", 1, 100);
    repeat (5) @(negedge clk);
    check_eq("irq_after_txc", irq, 1'b1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check_eq("irq_after_ack", irq, 1'b1);
    bus_read(SPDR_ADDR, rv);     check_eq("irq_rx", rv, 8'hC3);
    check_eq("irq_cleared", irq, 1'b0);
    bus_write(FIFOCTL_ADDR, 8'h01);
    check_eq("irq_txe", irq, 1'b1);
    bus_read(FIFOCTL_ADDR, rv);  check_eq("fifoctl_txeie", rv, 8'h01);

    // Asynchronous reset mid-transfer with two words still queued
    do_reset();
    core_lat = 20;
    bus_write(SPCR_ADDR, 8'hC0);
    repeat (3) @(negedge clk);
    bus_write(SPDR_ADDR, 8'hA0);
    bus_write(SPDR_ADDR, 8'hB0);
    bus_write(SPDR_ADDR, 8'hC0);
    wait_launches("busy_launch", 1, 50);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("busy_stat", rv, 8'h02);
    core_en = 1'b0;
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    check_eq("arst_cfg", {spe, spie, dord, cpol, cpha, clock_rate}, 8'h00);
    check_eq("arst_pb", pb, 5'h1F);
    check_eq("arst_txb_q", {tx_start, irq, txb, ram_q}, 18'h00000);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("arst_no_launch", launches.size(), 1);
    bus_read(FIFOSTAT_ADDR, rv); check_eq("arst_stat", rv, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
